gpu_text_blitter: RTL and testbench
===================================

Name: gpu_text_blitter

Overview:
Hardware clear/scroll/fill engine for the text-mode character buffer. It owns the buffer's CPU-side write port and merges two write sources: single-cell CPU writes and multi-cell engine commands. It maintains the circular top_line offset so scrolling needs no data copies. It sits between gpu_registers and character_buffer, replacing CPU-driven clear and scroll loops.

Parameters:
COLS, 80, max columns; 40-col mode uses COLS/2 as the row stride.
ROWS, 30, text rows.
ADDR_W, 12, buffer address width; must satisfy ROWS*COLS <= 2**ADDR_W.
DATA_W, 8, cell width (8 = char only; 16 = char plus attribute).
ROW_W, 5, row index width.
COL_W, 7, column index width.

Ports:
clk  in  1  system clock (clk_cpu domain)
rst_n  in  1  reset, synchronous, active-low
mode_80col  in  1  1 = stride COLS, 0 = stride COLS/2; sampled at command accept
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, can accept a command
cmd_op  in  2  0 CLEAR_ALL, 1 CLEAR_LINE, 2 SCROLL_UP, 3 CLEAR_EOL
cmd_row  in  ROW_W  logical row (CLEAR_LINE, CLEAR_EOL)
cmd_col  in  COL_W  start column (CLEAR_EOL)
cmd_count  in  ROW_W  scroll line count (SCROLL_UP)
cmd_fill  in  DATA_W  fill value
cpu_wr_en  in  1  single-cell write strobe
cpu_wr_row  in  ROW_W  logical row
cpu_wr_col  in  COL_W  column
cpu_wr_data  in  DATA_W  cell data
buf_addr  out  ADDR_W  character_buffer write address
buf_data  out  DATA_W  character_buffer write data
buf_we  out  1  character_buffer write enable
top_line  out  ROW_W  physical row shown at screen row 0
busy  out  1  command in progress (= !cmd_ready)
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (rst_n low at a clk edge): top_line=0, buf_we=0, buf_addr=0, buf_data=0, done=0, state=IDLE, so cmd_ready=1. Reset mid-command abandons the command; cells already written stay written.
- Physical row = (logical row + top_line) mod ROWS, computed by compare-subtract with no divider. Address = phys_row*stride + col, where stride = COLS or COLS/2.
- All buf_* outputs are registered: a write appears 1 cycle after its source cycle.
- A command is accepted when cmd_valid && cmd_ready. All cmd_* fields and mode_80col are latched on that cycle. The first engine write is issued the following cycle.
- FSM states:
  - IDLE: on accept -> FILL; for a SCROLL_UP with count 0 -> DONE.
  - FILL: one cell per cycle over the latched range; after the last cell -> ADVANCE for SCROLL_UP, otherwise -> DONE.
  - ADVANCE: top_line <= (top_line+1) mod ROWS; decrement the remaining count; if count > 0 -> FILL, else -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Fill ranges:
  - CLEAR_ALL: addresses 0..ROWS*stride-1; top_line is left unchanged.
  - CLEAR_LINE: the full logical row.
  - CLEAR_EOL: from cmd_col to stride-1 of the logical row.
  - SCROLL_UP: for each line, fill physical row top_line (the old top, which becomes the new bottom), then advance top_line. The count is clamped to ROWS.
- Degenerate commands (cmd_row >= ROWS, or cmd_col >= stride) perform no writes, go straight to DONE, and still pulse done.
- Arbitration: cpu_wr_en has priority every cycle. When it is asserted, the engine stalls (its fill counter holds) and the CPU write is issued. A CPU write is never dropped. cpu_wr_row >= ROWS or cpu_wr_col >= stride: the write is ignored.
- Ordering: a CPU write that lands in the not-yet-filled part of an active range is overwritten by the engine. Software must wait for !busy before writing.
- CPU writes map through the top_line value current in their source cycle.
- Throughput: N cells with no CPU stalls take N fill cycles plus 1 DONE cycle. SCROLL_UP adds 1 cycle per line for ADVANCE.

Decomposition:
- Package gpu_pkg holds: opcode localparams (OP_CLEAR_ALL=0, OP_CLEAR_LINE=1, OP_SCROLL_UP=2, OP_CLEAR_EOL=3), the FSM state encoding, default COLS/ROWS, and the space fill constant 8'h20.
- One sub-module, gpu_row_mapper: combinational logical-row to physical-row mapping plus address computation (stride select, range check). It is instantiated twice, once for the CPU path and once for the engine path.

Test Plan:
- Reset, then CLEAR_ALL, fill 8'h20, mode_80col=1 -> 2400 writes at addrs 0..2399; done 2401 cycles after accept; top_line=0.
- mode_80col=0, CLEAR_LINE row 3, top_line=0 -> 40 writes at addrs 120..159; then a CPU write at row 0 col 5 -> buf_addr=5 one cycle later.
- SCROLL_UP count 2 from top_line=28 -> rows 28 and 29 filled; top_line goes 29 then 0; done at 2*(80+1)+1 cycles. A CPU write at logical row 0 col 0 afterwards -> addr 0 (physical row 0).
- CLEAR_EOL row 1, col 78, 80-col mode -> exactly 2 writes (addrs 158 and 159). With col=90 -> 0 writes and done still pulses.
- cpu_wr_en held for 3 cycles during CLEAR_LINE -> 3 CPU writes interleaved, all 80 engine cells still written, completion delayed by 3 cycles.
- rst_n low mid CLEAR_ALL -> next cycle buf_we=0, cmd_ready=1, top_line=0, no done pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared opcodes, FSM encoding and defaults for the text-mode blitter.
package gpu_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [1:0] OP_CLEAR_ALL  = 2'd0;
  localparam logic [1:0] OP_CLEAR_LINE = 2'd1;
  localparam logic [1:0] OP_SCROLL_UP  = 2'd2;
  localparam logic [1:0] OP_CLEAR_EOL  = 2'd3;

  localparam logic [7:0] FILL_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/gpu_text_blitter_row_mapper.sv
// Logical row/column to character-buffer address, through the circular top_line.
module gpu_row_mapper
  import gpu_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 5,
  parameter int COL_W  = 7
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [ROW_W-1:0]  top_i,
  input  logic              mode_80col_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o
);

  localparam logic [ROW_W:0]   ROWS_W    = (ROW_W+1)'(ROWS);
  localparam logic [COL_W-1:0] STRIDE_80 = COL_W'(COLS);
  localparam logic [COL_W-1:0] STRIDE_40 = COL_W'(COLS/2);

  logic [ROW_W:0]   sum;
  logic [ROW_W:0]   phys;
  logic [COL_W-1:0] stride;

  // Both operands are below ROWS, so one conditional subtract replaces the modulo.
  always_comb begin
    stride  = mode_80col_i ? STRIDE_80 : STRIDE_40;
    sum     = {1'b0, row_i} + {1'b0, top_i};
    phys    = (sum >= ROWS_W) ? (sum - ROWS_W) : sum;
    valid_o = ({1'b0, row_i} < ROWS_W) && (col_i < stride);
    addr_o  = ADDR_W'(phys) * ADDR_W'(stride) + ADDR_W'(col_i);
  end

endmodule

// File: rtl/gpu_text_blitter.sv
// Clear/scroll/fill engine owning the character buffer write port.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// FILL    | one engine cell per cycle, stalls while a CPU write is present
// ADVANCE | scroll only: bump top_line, count down remaining lines
// DONE    | single-cycle completion pulse
module gpu_text_blitter
  import gpu_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int ROW_W  = 5,
  parameter int COL_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mode_80col_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ROW_W-1:0]  cmd_row_i,
  input  logic [COL_W-1:0]  cmd_col_i,
  input  logic [ROW_W-1:0]  cmd_count_i,
  input  logic [DATA_W-1:0] cmd_fill_i,
  input  logic              cpu_wr_en_i,
  input  logic [ROW_W-1:0]  cpu_wr_row_i,
  input  logic [COL_W-1:0]  cpu_wr_col_i,
  input  logic [DATA_W-1:0] cpu_wr_data_i,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [DATA_W-1:0] buf_data_o,
  output logic              buf_we_o,
  output logic [ROW_W-1:0]  top_line_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ROW_W-1:0] ROWS_R    = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] ROWS_LAST = ROW_W'(ROWS-1);
  localparam logic [COL_W-1:0] STRIDE_80 = COL_W'(COLS);
  localparam logic [COL_W-1:0] STRIDE_40 = COL_W'(COLS/2);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  top_q, top_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic [ADDR_W-1:0] cpu_addr, eng_addr;
  logic              cpu_valid, eng_valid;
  logic [ROW_W-1:0]  eng_row, eng_top;
  logic [COL_W-1:0]  last_col, cmd_stride;
  logic              cmd_degen;

  // CLEAR_ALL walks physical rows directly; SCROLL_UP fills the physical top row.
  assign eng_row = (op_q == OP_SCROLL_UP) ? top_q : row_q;
  assign eng_top = (op_q == OP_CLEAR_LINE || op_q == OP_CLEAR_EOL) ? top_q : '0;

  gpu_row_mapper #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W))
  u_cpu_map (
    .row_i(cpu_wr_row_i), .col_i(cpu_wr_col_i), .top_i(top_q),
    .mode_80col_i(mode_80col_i), .addr_o(cpu_addr), .valid_o(cpu_valid)
  );

  gpu_row_mapper #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W))
  u_eng_map (
    .row_i(eng_row), .col_i(col_q), .top_i(eng_top),
    .mode_80col_i(mode_q), .addr_o(eng_addr), .valid_o(eng_valid)
  );

  assign last_col    = (mode_q ? STRIDE_80 : STRIDE_40) - 1'b1;
  assign cmd_stride  = mode_80col_i ? STRIDE_80 : STRIDE_40;
  assign cmd_degen   = ((cmd_op_i == OP_CLEAR_LINE || cmd_op_i == OP_CLEAR_EOL) && (cmd_row_i >= ROWS_R))
                    || ((cmd_op_i == OP_CLEAR_EOL) && (cmd_col_i >= cmd_stride))
                    || ((cmd_op_i == OP_SCROLL_UP) && (cmd_count_i == '0));
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = ~cmd_ready_o;
  assign done_o      = (state_q == ST_DONE);
  assign buf_we_o    = buf_we_q;
  assign buf_addr_o  = buf_addr_q;
  assign buf_data_o  = buf_data_q;
  assign top_line_o  = top_q;

  // Next-state, range walking and write-port arbitration (CPU wins, engine holds).
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mode_d     = mode_q;
    fill_d     = fill_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    top_d      = top_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;

    if (cpu_wr_en_i && cpu_valid) begin
      buf_we_d   = 1'b1;
      buf_addr_d = cpu_addr;
      buf_data_d = cpu_wr_data_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          mode_d  = mode_80col_i;
          fill_d  = cmd_fill_i;
          row_d   = (cmd_op_i == OP_CLEAR_ALL) ? '0 : cmd_row_i;
          col_d   = (cmd_op_i == OP_CLEAR_EOL) ? cmd_col_i : '0;
          cnt_d   = (cmd_count_i > ROWS_R) ? ROWS_R : cmd_count_i;
          state_d = cmd_degen ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (!cpu_wr_en_i) begin
          if (eng_valid) begin
            buf_we_d   = 1'b1;
            buf_addr_d = eng_addr;
            buf_data_d = fill_q;
          end
          if (col_q == last_col) begin
            if (op_q == OP_CLEAR_ALL && row_q != ROWS_LAST) begin
              row_d = row_q + 1'b1;
              col_d = '0;
            end else if (op_q == OP_SCROLL_UP) begin
              state_d = ST_ADVANCE;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_ADVANCE: begin
        top_d   = (top_q == ROWS_LAST) ? '0 : top_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        col_d   = '0;
        state_d = (cnt_q > ROW_W'(1)) ? ST_FILL : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered write port, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CLEAR_ALL;
      mode_q     <= 1'b0;
      fill_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      top_q      <= '0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mode_q     <= mode_d;
      fill_q     <= fill_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      top_q      <= top_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_gpu_text_blitter.sv
// Self-checking bench for gpu_text_blitter: directed vector table, corner sequences, random commands.
module tb_gpu_text_blitter;
  import gpu_pkg::*;

  localparam int COLS = 80, ROWS = 30, ADDR_W = 12, DATA_W = 8, ROW_W = 5, COL_W = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, mode_80col, cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ROW_W-1:0]  cmd_row, cmd_count, cpu_wr_row, top_line;
  logic [COL_W-1:0]  cmd_col, cpu_wr_col;
  logic [DATA_W-1:0] cmd_fill, cpu_wr_data, buf_data;
  logic              cpu_wr_en, buf_we, busy, done;
  logic [ADDR_W-1:0] buf_addr;

  gpu_text_blitter dut (
    .clk_i(clk), .rst_n_i(rst_n), .mode_80col_i(mode_80col),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_row_i(cmd_row), .cmd_col_i(cmd_col), .cmd_count_i(cmd_count), .cmd_fill_i(cmd_fill),
    .cpu_wr_en_i(cpu_wr_en), .cpu_wr_row_i(cpu_wr_row), .cpu_wr_col_i(cpu_wr_col),
    .cpu_wr_data_i(cpu_wr_data), .buf_addr_o(buf_addr), .buf_data_o(buf_data),
    .buf_we_o(buf_we), .top_line_o(top_line), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [1:0] op; int row; int col; int cnt; logic [7:0] fill; logic mode;
    int exp_writes; int exp_cycles; int exp_top; int exp_first;
  } vec_t;

  vec_t        vecs [9];
  logic [7:0]  ref_mem [4096];
  logic [7:0]  dut_mem [4096];
  int          ref_top;
  logic [19:0] obs_q [$];
  logic [19:0] exp_q [$];
  int          n_pass = 0, n_total = 0;

  // Capture every buffer write as the DUT presents it.
  always @(negedge clk) begin
    if (buf_we) begin
      dut_mem[buf_addr] = buf_data;
      obs_q.push_back({buf_addr, buf_data});
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push_exp(input int a, input logic [7:0] d);
    logic [11:0] a12;
    a12 = a[11:0];
    exp_q.push_back({a12, d});
    ref_mem[a] = d;
  endfunction

  function automatic void cpu_map(input int row, input int col, input logic mode,
                                  output int a, output bit v);
    int stride;
    stride = mode ? COLS : COLS/2;
    v = (row < ROWS) && (col < stride);
    a = ((row + ref_top) % ROWS) * stride + col;
  endfunction

  // Reference: which cells a command must write, in order, and how many scroll lines it takes.
  function automatic void model_cmd(input logic [1:0] op, input int row, input int col, input int cnt,
                                    input logic [7:0] fill, input logic mode, output int lines);
    int stride;
    int phys;
    stride = mode ? COLS : COLS/2;
    lines = 0;
    exp_q.delete();
    case (op)
      OP_CLEAR_ALL:  for (int a = 0; a < ROWS*stride; a++) push_exp(a, fill);
      OP_CLEAR_LINE: if (row < ROWS) begin
        phys = (row + ref_top) % ROWS;
        for (int c = 0; c < stride; c++) push_exp(phys*stride + c, fill);
      end
      OP_CLEAR_EOL: if (row < ROWS && col < stride) begin
        phys = (row + ref_top) % ROWS;
        for (int c = col; c < stride; c++) push_exp(phys*stride + c, fill);
      end
      default: begin
        lines = (cnt > ROWS) ? ROWS : cnt;
        for (int l = 0; l < lines; l++) begin
          for (int c = 0; c < stride; c++) push_exp(ref_top*stride + c, fill);
          ref_top = (ref_top + 1) % ROWS;
        end
      end
    endcase
  endfunction

  task automatic run_cmd(input string tag, input logic [1:0] op, input int row, input int col,
                         input int cnt, input logic [7:0] fill, input logic mode,
                         input int st, input int sl, input int crow, input int ccol,
                         output int cycles, output int nwr);
    int lines, a, bad, got;
    bit v;
    check({tag, "_ready"}, cmd_ready, 1);
    model_cmd(op, row, col, cnt, fill, mode, lines);
    for (int i = 0; i < sl; i++) begin
      cpu_map(crow, ccol + i, mode, a, v);
      if (v) begin
        exp_q.insert(st - 1 + i, {a[11:0], 8'h55});
        ref_mem[a] = 8'h55;
      end
    end
    obs_q.delete();
    cmd_valid = 1'b1; cmd_op = op; cmd_row = ROW_W'(row); cmd_col = COL_W'(col);
    cmd_count = ROW_W'(cnt); cmd_fill = fill; mode_80col = mode;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cycles = 0; got = 0;
    while (cycles < 3000) begin
      cycles++;
      if (cycles >= st && cycles < st + sl) begin
        cpu_wr_en = 1'b1; cpu_wr_row = ROW_W'(crow);
        cpu_wr_col = COL_W'(ccol + cycles - st); cpu_wr_data = 8'h55;
      end else cpu_wr_en = 1'b0;
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
    end
    cpu_wr_en = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_cycles"}, cycles, exp_q.size() + 1 + lines);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
    nwr = obs_q.size();
    check({tag, "_nwrites"}, nwr, exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    check({tag, "_order_first_bad"}, bad, -1);
    check({tag, "_top_line"}, top_line, ref_top);
  endtask

  task automatic cpu_write(input string tag, input int row, input int col,
                           input logic [7:0] d, input logic mode);
    int a;
    bit v;
    cpu_map(row, col, mode, a, v);
    mode_80col = mode; cpu_wr_en = 1'b1; cpu_wr_row = ROW_W'(row);
    cpu_wr_col = COL_W'(col); cpu_wr_data = d;
    @(negedge clk);
    check({tag, "_we_not_early"}, buf_we, 0);
    @(posedge clk); #1;
    cpu_wr_en = 1'b0;
    @(negedge clk);
    check({tag, "_we"}, buf_we, v);
    if (v) begin
      check({tag, "_addr"}, buf_addr, a);
      check({tag, "_data"}, buf_data, d);
      ref_mem[a] = d;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, nw, bad, saw;
    logic [1:0] rop;

    for (int a = 0; a < 4096; a++) begin ref_mem[a] = 8'h00; dut_mem[a] = 8'h00; end
    ref_top = 0;
    rst_n = 1'b0; mode_80col = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0;
    cmd_col = '0; cmd_count = '0; cmd_fill = '0; cpu_wr_en = 1'b0; cpu_wr_row = '0;
    cpu_wr_col = '0; cpu_wr_data = '0;

    vecs[0] = '{OP_CLEAR_ALL,  0,  0,  0, FILL_SPACE, 1'b1, 2400, 2401,  0,    0};
    vecs[1] = '{OP_CLEAR_LINE, 3,  0,  0, 8'h41,      1'b0,   40,   41,  0,  120};
    vecs[2] = '{OP_SCROLL_UP,  0,  0, 28, 8'h42,      1'b1, 2240, 2269, 28,    0};
    vecs[3] = '{OP_SCROLL_UP,  0,  0,  2, 8'h43,      1'b1,  160,  163,  0, 2240};
    vecs[4] = '{OP_CLEAR_EOL,  1, 78,  0, 8'h44,      1'b1,    2,    3,  0,  158};
    vecs[5] = '{OP_CLEAR_EOL,  1, 90,  0, 8'h45,      1'b1,    0,    1,  0,   -1};
    vecs[6] = '{OP_CLEAR_LINE, 30, 0,  0, 8'h46,      1'b1,    0,    1,  0,   -1};
    vecs[7] = '{OP_SCROLL_UP,  0,  0,  0, 8'h47,      1'b1,    0,    1,  0,   -1};
    vecs[8] = '{OP_SCROLL_UP,  0,  0, 31, 8'h48,      1'b0, 1200, 1231,  0,    0};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_data", buf_data, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_top_line", top_line, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].row, vecs[i].col, vecs[i].cnt,
              vecs[i].fill, vecs[i].mode, 0, 0, 0, 0, cyc, nw);
      check($sformatf("vec%0d_tbl_writes", i), nw, vecs[i].exp_writes);
      check($sformatf("vec%0d_tbl_cycles", i), cyc, vecs[i].exp_cycles);
      check($sformatf("vec%0d_tbl_top", i), top_line, vecs[i].exp_top);
      if (vecs[i].exp_first >= 0 && nw > 0)
        check($sformatf("vec%0d_tbl_first_addr", i), obs_q[0][19:8], vecs[i].exp_first);
    end

    cpu_write("cpu_r0c5", 0, 5, 8'h61, 1'b0);
    cpu_write("cpu_r0c0", 0, 0, 8'h62, 1'b1);
    cpu_write("cpu_col_oob", 0, 50, 8'h63, 1'b0);
    cpu_write("cpu_row_oob", 30, 0, 8'h64, 1'b1);

    run_cmd("stall", OP_CLEAR_LINE, 5, 0, 0, 8'hAA, 1'b1, 10, 3, 10, 1, cyc, nw);
    check("stall_tbl_writes", nw, 83);
    check("stall_tbl_cycles", cyc, 84);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(1, 3));
      if (i % 8 == 0) rop = OP_CLEAR_ALL;
      run_cmd($sformatf("rnd%0d", i), rop, $urandom_range(0, 31), $urandom_range(0, 90),
              (i == 5) ? 31 : $urandom_range(0, 3), 8'($urandom), 1'($urandom), 0, 0, 0, 0, cyc, nw);
      cpu_write($sformatf("rndcpu%0d", i), $urandom_range(0, 31), $urandom_range(0, 85),
                8'($urandom), 1'($urandom));
    end

    bad = 0;
    for (int a = 0; a < 4096; a++) if (ref_mem[a] !== dut_mem[a]) bad++;
    check("mem_image_mismatches", bad, 0);

    if (ref_top == 0) run_cmd("pre_rst_scroll", OP_SCROLL_UP, 0, 0, 1, 8'h20, 1'b1, 0, 0, 0, 0, cyc, nw);
    cmd_valid = 1'b1; cmd_op = OP_CLEAR_ALL; cmd_fill = 8'h77; mode_80col = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    @(negedge clk);
    check("midcmd_writing", buf_we, 1);
    check("midcmd_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_buf_we", buf_we, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_top_line", top_line, 0);
    check("midrst_done", done, 0);
    saw = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || buf_we) saw++;
    end
    check("midrst_no_done_no_write", saw, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
